// File: rtl/tlul_pkg.sv
// TL-UL bus types, opcode encodings and the register-adapter FSM state type.
package tlul_pkg;

    localparam int TL_AW  = 32;
    localparam int TL_DW  = 32;
    localparam int TL_AIW = 8;
    localparam int TL_DIW = 1;
    localparam int TL_SZW = 2;
    localparam int TL_DBW = TL_DW / 8;

    localparam logic [TL_DW-1:0] TL_ERR_RDATA = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    // Opcode fields are plain vectors so illegal encodings can travel on the bus.
    typedef struct packed {
        logic              a_valid;
        logic [2:0]        a_opcode;
        logic [2:0]        a_param;
        logic [TL_SZW-1:0] a_size;
        logic [TL_AIW-1:0] a_source;
        logic [TL_AW-1:0]  a_address;
        logic [TL_DBW-1:0] a_mask;
        logic [TL_DW-1:0]  a_data;
        logic              d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic              d_valid;
        logic [2:0]        d_opcode;
        logic [2:0]        d_param;
        logic [TL_SZW-1:0] d_size;
        logic [TL_AIW-1:0] d_source;
        logic [TL_DIW-1:0] d_sink;
        logic [TL_DW-1:0]  d_data;
        logic              d_error;
        logic              a_ready;
    } tl_d2h_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RSP
    } reg_lite_state_e;

    function automatic logic tl_is_put(input logic [2:0] op);
        return (op == PutFullData) || (op == PutPartialData);
    endfunction

endpackage

// File: rtl/tlul_req_err_chk.sv
// Combinational TL-UL A-channel legality check for simple register devices.
module tlul_req_err_chk
    import tlul_pkg::*;
(
    input  tl_h2d_t i_tl,
    output logic    o_err
);

    logic w_bad_op;
    logic w_bad_align;
    logic w_bad_size;
    logic w_bad_mask;
    logic w_unused;

    assign w_bad_op    = !((i_tl.a_opcode == Get) || tl_is_put(i_tl.a_opcode));
    assign w_bad_align = (i_tl.a_address[1:0] != 2'b00);
    assign w_bad_size  = (i_tl.a_size > TL_SZW'(2));
    assign w_bad_mask  = ((i_tl.a_opcode == PutFullData) && (i_tl.a_mask != '1))
                       || (tl_is_put(i_tl.a_opcode) && (i_tl.a_mask == '0));

    assign o_err = w_bad_op | w_bad_align | w_bad_size | w_bad_mask;

    assign w_unused = ^{i_tl.a_valid, i_tl.a_param, i_tl.a_source,
                        i_tl.a_address[TL_AW-1:2], i_tl.a_data, i_tl.d_ready};

endmodule

// File: rtl/tlul_adapter_reg_lite.sv
// TL-UL device endpoint turning A-channel requests into single-cycle register strobes.
// Optional TLUL_ADAPTER_REG_BUSY_EN adds busy_i, which back-pressures a_ready in IDLE.
module tlul_adapter_reg_lite
    import tlul_pkg::*;
#(
    parameter int RegAw         = 8,
    parameter int AccessLatency = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  tl_h2d_t           tl_i,
    output tl_d2h_t           tl_o,
    output logic              re_o,
    output logic              we_o,
    output logic [RegAw-1:0]  addr_o,
    output logic [TL_DW-1:0]  wdata_o,
    output logic [TL_DBW-1:0] be_o,
    input  logic [TL_DW-1:0]  rdata_i,
    input  logic              error_i
`ifdef TLUL_ADAPTER_REG_BUSY_EN
    ,
    input  logic              busy_i
`endif
);

    if ((AccessLatency != 0) && (AccessLatency != 1)) begin : g_bad_latency
        $fatal(1, "tlul_adapter_reg_lite: AccessLatency must be 0 or 1");
    end

    reg_lite_state_e r_state, w_state_nxt;

    logic w_err, w_a_ready, w_accept, w_is_get, w_is_put, w_sample;
    logic r_is_read, r_err, r_rerr;
    logic [TL_AIW-1:0] r_source;
    logic [TL_SZW-1:0] r_size;
    logic [TL_DW-1:0]  r_rdata, r_wdata;
    logic [RegAw-1:0]  r_addr;
    logic [TL_DBW-1:0] r_be;
    logic w_unused;

    tlul_req_err_chk u_err_chk (
        .i_tl  (tl_i),
        .o_err (w_err)
    );

`ifdef TLUL_ADAPTER_REG_BUSY_EN
    assign w_a_ready = (r_state == IDLE) & ~busy_i;
`else
    assign w_a_ready = (r_state == IDLE);
`endif

    assign w_accept = tl_i.a_valid & w_a_ready;
    assign w_is_get = (tl_i.a_opcode == Get);
    assign w_is_put = tl_is_put(tl_i.a_opcode);
    // Zero latency samples in the accept cycle; otherwise in WAIT (errored requests never get there).
    assign w_sample = (AccessLatency == 0) ? (w_accept & ~w_err) : (r_state == WAIT);
    assign w_unused = ^{tl_i.a_param, tl_i.a_address};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_state_nxt = (w_err || (AccessLatency == 0)) ? RSP : WAIT;
            WAIT:    w_state_nxt = RSP;
            RSP:     if (tl_i.d_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        re_o    = w_accept & w_is_get & ~w_err;
        we_o    = w_accept & w_is_put & ~w_err;
        addr_o  = (r_state == IDLE) ? tl_i.a_address[RegAw-1:0] : r_addr;
        wdata_o = (r_state == IDLE) ? tl_i.a_data : r_wdata;
        be_o    = (r_state == IDLE) ? tl_i.a_mask : r_be;

        tl_o         = '0;
        tl_o.a_ready = w_a_ready;
        if (r_state == RSP) begin
            tl_o.d_valid  = 1'b1;
            tl_o.d_opcode = r_is_read ? AccessAckData : AccessAck;
            tl_o.d_size   = r_size;
            tl_o.d_source = r_source;
            tl_o.d_error  = r_err | r_rerr;
            tl_o.d_data   = r_is_read ? (r_err ? TL_ERR_RDATA : r_rdata) : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_addr    <= '0;
            r_wdata   <= '0;
            r_be      <= '0;
            r_source  <= '0;
            r_size    <= '0;
            r_is_read <= 1'b0;
            r_err     <= 1'b0;
            r_rdata   <= '0;
            r_rerr    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr    <= tl_i.a_address[RegAw-1:0];
                r_wdata   <= tl_i.a_data;
                r_be      <= tl_i.a_mask;
                r_source  <= tl_i.a_source;
                r_size    <= tl_i.a_size;
                r_is_read <= w_is_get;
                r_err     <= w_err;
                r_rdata   <= '0;
                r_rerr    <= 1'b0;
            end
            if (w_sample) begin
                r_rdata <= rdata_i;
                r_rerr  <= error_i;
            end
        end
    end

endmodule

// File: tb/tb_tlul_adapter_reg_lite.sv
// Directed scoreboard bench for tlul_adapter_reg_lite at AccessLatency 0 and 1.
module tb_tlul_adapter_reg_lite;
    import tlul_pkg::*;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] data;
        bit          chk_data;
        logic        err;
        logic [7:0]  src;
        logic [1:0]  size;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    tl_h2d_t req, tl_i0, tl_i1;
    tl_d2h_t tl_o0, tl_o1, o;
    logic        re0, we0, re1, we1, ore, owe;
    logic [7:0]  addr0, addr1, oaddr;
    logic [31:0] wd0, wd1, owd;
    logic [3:0]  be0, be1, obe;
    logic [31:0] rdata;
    logic        rerr;
    bit          sel;
`ifdef TLUL_ADAPTER_REG_BUSY_EN
    logic        busy;
`endif

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    assign tl_i0 = sel ? tl_h2d_t'('0) : req;
    assign tl_i1 = sel ? req : tl_h2d_t'('0);

    always_comb begin
        o     = sel ? tl_o1 : tl_o0;
        ore   = sel ? re1 : re0;
        owe   = sel ? we1 : we0;
        oaddr = sel ? addr1 : addr0;
        owd   = sel ? wd1 : wd0;
        obe   = sel ? be1 : be0;
    end

    tlul_adapter_reg_lite #(.RegAw(8), .AccessLatency(0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .tl_i(tl_i0), .tl_o(tl_o0),
        .re_o(re0), .we_o(we0), .addr_o(addr0), .wdata_o(wd0), .be_o(be0),
        .rdata_i(rdata), .error_i(rerr)
`ifdef TLUL_ADAPTER_REG_BUSY_EN
        , .busy_i(busy)
`endif
    );

    tlul_adapter_reg_lite #(.RegAw(8), .AccessLatency(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .tl_i(tl_i1), .tl_o(tl_o1),
        .re_o(re1), .we_o(we1), .addr_o(addr1), .wdata_o(wd1), .be_o(be1),
        .rdata_i(rdata), .error_i(rerr)
`ifdef TLUL_ADAPTER_REG_BUSY_EN
        , .busy_i(busy)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic model_err(input logic [2:0] op, input logic [31:0] addr,
                                       input logic [1:0] size, input logic [3:0] mask);
        logic is_put;
        is_put = (op == 3'h0) || (op == 3'h1);
        return !(op == 3'h4 || is_put) || (addr[1:0] != 2'b00) || (size > 2'd2)
               || (op == 3'h0 && mask != 4'hF) || (is_put && mask == 4'h0);
    endfunction

    // Drives one request through its accept cycle and pushes the expected response.
    task automatic send(input logic [2:0] op, input logic [31:0] addr, input logic [1:0] size,
                        input logic [3:0] mask, input logic [31:0] data, input logic [7:0] src,
                        input logic [31:0] rd, input logic re, input string tag);
        exp_t e;
        logic bad, is_put;
        bad    = model_err(op, addr, size, mask);
        is_put = (op == 3'h0) || (op == 3'h1);
        e.op       = (op == 3'h4) ? 3'h1 : 3'h0;
        e.data     = (op == 3'h4) ? (bad ? 32'hFFFF_FFFF : rd) : 32'h0;
        e.chk_data = !(re && !bad && op == 3'h4);
        e.err      = bad | re;
        e.src      = src;
        e.size     = size;
        e.lat      = (bad || !sel) ? 1 : 2;

        @(negedge clk);
        req           = '0;
        req.a_valid   = 1'b1;
        req.a_opcode  = op;
        req.a_address = addr;
        req.a_size    = size;
        req.a_mask    = mask;
        req.a_data    = data;
        req.a_source  = src;
        if (sel) begin rdata = ~rd; rerr = 1'b0; end
        else     begin rdata = rd;  rerr = re;   end
        #1;
        chk({tag, "_aready_acc"}, o.a_ready, 1);
        chk({tag, "_re_acc"}, ore, (op == 3'h4) && !bad);
        chk({tag, "_we_acc"}, owe, is_put && !bad);
        chk({tag, "_addr_acc"}, oaddr, addr[7:0]);
        chk({tag, "_wdata_acc"}, owd, data);
        chk({tag, "_be_acc"}, obe, mask);
        sb.push_back(e);

        @(negedge clk);
        req.a_valid   = 1'b0;
        req.a_address = 32'hFFFF_FFF0;
        req.a_data    = ~data;
        req.a_mask    = ~mask;
        if (sel) begin rdata = rd;  rerr = re;  end
        else     begin rdata = ~rd; rerr = ~re; end
        #1;
        chk({tag, "_re_after"}, ore, 0);
        chk({tag, "_we_after"}, owe, 0);
        chk({tag, "_aready_busy"}, o.a_ready, 0);
        chk({tag, "_addr_held"}, oaddr, addr[7:0]);
        chk({tag, "_wdata_held"}, owd, data);
        chk({tag, "_be_held"}, obe, mask);
    endtask

    // Waits (bounded) for d_valid, compares against the scoreboard, then handshakes.
    task automatic recv(input int hold, input string tag);
        exp_t e;
        int lat;
        lat = 1;
        while (!o.d_valid && lat < 6) begin
            @(negedge clk);
            lat++;
            rdata = 32'h5A5A_5A5A;
            rerr  = 1'b1;
            #1;
        end
        chk({tag, "_sb_nonempty"}, sb.size() != 0, 1);
        e = sb.pop_front();
        chk({tag, "_latency"}, lat, e.lat);
        chk({tag, "_dvalid"}, o.d_valid, 1);
        chk({tag, "_dopcode"}, o.d_opcode, e.op);
        if (e.chk_data) chk({tag, "_ddata"}, o.d_data, e.data);
        chk({tag, "_derror"}, o.d_error, e.err);
        chk({tag, "_dsource"}, o.d_source, e.src);
        chk({tag, "_dsize"}, o.d_size, e.size);
        chk({tag, "_dparam_sink"}, {o.d_param, o.d_sink}, 0);
        chk({tag, "_aready_rsp"}, o.a_ready, 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            #1;
            chk({tag, "_hold_dvalid"}, o.d_valid, 1);
            chk({tag, "_hold_dopcode"}, o.d_opcode, e.op);
            if (e.chk_data) chk({tag, "_hold_ddata"}, o.d_data, e.data);
            chk({tag, "_hold_derror"}, o.d_error, e.err);
            chk({tag, "_hold_dsource"}, o.d_source, e.src);
            chk({tag, "_hold_aready"}, o.a_ready, 0);
        end
        @(negedge clk);
        req.d_ready = 1'b1;
        #1;
        chk({tag, "_dvalid_hs"}, o.d_valid, 1);
        @(negedge clk);
        req.d_ready = 1'b0;
        #1;
        chk({tag, "_dvalid_done"}, o.d_valid, 0);
        chk({tag, "_aready_done"}, o.a_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        req   = '0;
        rdata = '0;
        rerr  = 1'b0;
        sel   = 1'b0;
`ifdef TLUL_ADAPTER_REG_BUSY_EN
        busy  = 1'b0;
`endif
        #1;
        chk("rst_dvalid0", tl_o0.d_valid, 0);
        chk("rst_dvalid1", tl_o1.d_valid, 0);
        chk("rst_aready0", tl_o0.a_ready, 1);
        chk("rst_aready1", tl_o1.a_ready, 1);
        chk("rst_ddata0", tl_o0.d_data, 0);
        chk("rst_strobes", {re0, we0, re1, we1}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        sel = 1'b0;
        send(Get, 32'h10, 2'd2, 4'hF, 32'h0, 8'h05, 32'hDEAD_BEEF, 1'b0, "l0_get");
        recv(0, "l0_get");
        send(PutPartialData, 32'h24, 2'd1, 4'b0011, 32'h1234_ABCD, 8'h06, 32'h0, 1'b0, "l0_putp");
        recv(0, "l0_putp");
        send(Get, 32'h13, 2'd2, 4'hF, 32'h0, 8'h07, 32'h1111_1111, 1'b0, "l0_misalign");
        recv(0, "l0_misalign");
        send(PutFullData, 32'h20, 2'd2, 4'h7, 32'hAAAA_5555, 8'h08, 32'h0, 1'b0, "l0_pfmask");
        recv(0, "l0_pfmask");
        send(3'h5, 32'h20, 2'd2, 4'hF, 32'h0, 8'h09, 32'h0, 1'b0, "l0_badop");
        recv(0, "l0_badop");
        send(Get, 32'h30, 2'd3, 4'hF, 32'h0, 8'h0A, 32'h2222_3333, 1'b0, "l0_bigsize");
        recv(1, "l0_bigsize");
        send(PutPartialData, 32'h34, 2'd2, 4'h0, 32'h7777_8888, 8'h0B, 32'h0, 1'b0, "l0_pmask0");
        recv(0, "l0_pmask0");
        send(PutFullData, 32'h3C, 2'd2, 4'hF, 32'hCAFE_0001, 8'hA7, 32'h0, 1'b0, "l0_putf");
        recv(0, "l0_putf");

        @(negedge clk);
        req.d_ready = 1'b1;
        #1;
        chk("idle_dready_dvalid", o.d_valid, 0);
        chk("idle_dready_aready", o.a_ready, 1);
        @(negedge clk);
        req.d_ready = 1'b0;
        #1;
        chk("idle_dready_after", o.a_ready, 1);

        sel = 1'b1;
        send(Get, 32'h48, 2'd2, 4'hF, 32'h0, 8'h21, 32'h1357_9BDF, 1'b1, "l1_get_err");
        recv(3, "l1_get_err");
        send(Get, 32'h4C, 2'd2, 4'hF, 32'h0, 8'h22, 32'hCAFE_F00D, 1'b0, "l1_get");
        recv(0, "l1_get");
        send(PutFullData, 32'h52, 2'd2, 4'hF, 32'h0BAD_0BAD, 8'h23, 32'h0, 1'b0, "l1_put_misalign");
        recv(0, "l1_put_misalign");
        send(PutFullData, 32'h50, 2'd2, 4'hF, 32'h89AB_CDEF, 8'h24, 32'h0, 1'b0, "l1_putf");
        recv(0, "l1_putf");

        sel = 1'b0;
        send(Get, 32'h40, 2'd2, 4'hF, 32'h0, 8'h11, 32'h0BAD_F00D, 1'b0, "rst_mid");
        chk("rst_mid_pre_dvalid", o.d_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_dvalid", o.d_valid, 0);
        chk("rst_mid_aready", o.a_ready, 1);
        chk("rst_mid_strobe", {ore, owe}, 0);
        void'(sb.pop_front());
        @(negedge clk);
        rst_n = 1'b1;
        send(Get, 32'h44, 2'd2, 4'hF, 32'h0, 8'h12, 32'h600D_CAFE, 1'b0, "post_rst");
        recv(0, "post_rst");

`ifdef TLUL_ADAPTER_REG_BUSY_EN
        @(negedge clk);
        busy          = 1'b1;
        req           = '0;
        req.a_valid   = 1'b1;
        req.a_opcode  = Get;
        req.a_address = 32'h08;
        req.a_size    = 2'd2;
        req.a_mask    = 4'hF;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("busy_aready", o.a_ready, 0);
            chk("busy_strobe", {ore, owe}, 0);
            @(negedge clk);
        end
        req.a_valid = 1'b0;
        busy        = 1'b0;
        #1;
        chk("busy_release_aready", o.a_ready, 1);
        chk("busy_release_dvalid", o.d_valid, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
